irq_aggregator: RTL and testbench

- Avalon-MM slave that collects up to 16 interrupt sources (interval timer `irq`, PIOs, UARTs) into one CPU-facing interrupt line.
- Sits directly downstream of the timer and peripheral `irq` outputs.
- Adds per-source synchronisation, edge/level selection, pending latches, enable mask, software force and a priority vector register.
- Register access mirrors the timer: 3-bit word address, 16-bit data, registered readdata.

---
 rtl/irq_aggregator.sv | 106 ++++++++++
 tb/tb_irq_aggregator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_aggregator.sv
// Purpose: merges NUM_IRQ async interrupt sources into one registered CPU interrupt, Avalon-MM register access.
// Latency: source -> PENDING SYNC_STAGES+1 cycles, -> irq one more; readdata one cycle after address.
// Backpressure: none; the slave accepts every access with zero wait states.
module irq_aggregator #(
    parameter int          NUM_IRQ      = 8,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [15:0] RESET_ENABLE = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [15:0]        readdata,
    output logic               irq
);

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] sync_d;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] edge_mode;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] wdata;
    logic               wr_en;
    logic               wr_pend;
    logic               wr_enable;
    logic               wr_edge;
    logic               wr_force;
    logic [3:0]         vec_idx;
    logic [15:0]        rd_mux;
    logic               unused_wdata;

    assign wdata        = writedata[NUM_IRQ-1:0];
    assign unused_wdata = ^writedata;

    assign wr_en     = chipselect & ~write_n;
    assign wr_pend   = wr_en && (address == 3'd0);
    assign wr_enable = wr_en && (address == 3'd1);
    assign wr_edge   = wr_en && (address == 3'd2);
    assign wr_force  = wr_en && (address == 3'd5);

    // Synchroniser shifts toward the MSB slice; the last slice is the clean source.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            sync_d <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            sync_d <= sync_s;
        end
    end

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_s & ~sync_d;
    assign set_vec  = (edge_mode & edge_det) | (~edge_mode & sync_s) | ({NUM_IRQ{wr_force}} & wdata);
    assign clr_vec  = {NUM_IRQ{wr_pend}} & wdata;
    assign active   = pending & enable;

    // A set in the same cycle as a W1C wins, so a live level source cannot be cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            enable    <= RESET_ENABLE[NUM_IRQ-1:0];
            edge_mode <= '0;
            irq       <= 1'b0;
        end else begin
            pending <= set_vec | (pending & ~clr_vec);
            if (wr_enable) enable <= wdata;
            if (wr_edge) edge_mode <= wdata;
            irq <= |active;
        end
    end

    // Scan from the top so the lowest active index is the one left standing.
    always_comb begin
        vec_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) vec_idx = 4'(i);
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            3'd0: rd_mux = 16'(pending);
            3'd1: rd_mux = 16'(enable);
            3'd2: rd_mux = 16'(edge_mode);
            3'd3: rd_mux = 16'(active);
            3'd4: rd_mux = (|active) ? {1'b1, 11'b0, vec_idx} : 16'h0000;
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= 16'h0000;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed bench for irq_aggregator: stimulus queues expected read/irq values,
// a negedge monitor pops them one cycle after each issued read.
module tb_irq_aggregator;

    localparam int          NUM_IRQ = 8;
    localparam logic [15:0] RST_EN  = 16'h0021;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [2:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [15:0]        writedata;
    logic [NUM_IRQ-1:0] irq_in;
    logic [15:0]        readdata;
    logic               irq;

    typedef struct {
        logic        chk_irq;
        logic [15:0] rd;
        logic        irq;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  issue = 1'b0;
    logic  obs   = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;

    irq_aggregator #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (2),
        .RESET_ENABLE(RST_EN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .irq_in    (irq_in),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, req);
        end
    endtask

    // Read data is valid one cycle after the address is presented.
    always @(posedge clk) obs <= issue;

    always @(negedge clk) begin
        if (obs) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL monitor: read observed with empty scoreboard");
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, readdata, e.rd);
                if (e.chk_irq) check({nm, "_irq"}, {15'b0, irq}, {15'b0, e.irq});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input logic ci,
                      input logic ei, input string nm);
        exp_t x;
        x.chk_irq = ci;
        x.rd      = e;
        x.irq     = ei;
        exp_q.push_back(x);
        name_q.push_back(nm);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        issue      = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        issue      = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rst_tab [8];
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_in     = '0;
        rst_tab    = '{16'h0000, RST_EN, 16'h0000, 16'h0000,
                       16'h0000, 16'h0000, 16'h0000, 16'h0000};
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state of every address.
        for (int a = 0; a < 8; a++) rd(3'(a), rst_tab[a], 1'b1, 1'b0, $sformatf("reset_addr%0d", a));

        // Edge mode, one-cycle pulse on bit 4: exact latency of PENDING and irq.
        wr(3'd1, 16'h0010);
        wr(3'd2, 16'h0010);
        irq_in[4] = 1'b1;
        tick(1);
        irq_in[4] = 1'b0;
        rd(3'd0, 16'h0000, 1'b1, 1'b0, "edge_n2");
        rd(3'd0, 16'h0000, 1'b1, 1'b0, "edge_n3");
        rd(3'd0, 16'h0010, 1'b1, 1'b1, "edge_n4");
        rd(3'd4, 16'h8004, 1'b1, 1'b1, "edge_vector");
        rd(3'd3, 16'h0010, 1'b0, 1'b0, "edge_active");
        wr(3'd0, 16'h0010);
        rd(3'd0, 16'h0000, 1'b1, 1'b0, "edge_w1c");
        rd(3'd0, 16'h0000, 1'b1, 1'b0, "edge_w1c_hold");

        // Level mode bit 2: W1C has no effect while the source is high.
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0004);
        irq_in[2] = 1'b1;
        tick(4);
        rd(3'd0, 16'h0004, 1'b1, 1'b1, "level_set");
        wr(3'd0, 16'h0004);
        rd(3'd0, 16'h0004, 1'b1, 1'b1, "level_w1c_blocked");
        irq_in[2] = 1'b0;
        tick(3);
        wr(3'd0, 16'h0004);
        rd(3'd0, 16'h0000, 1'b1, 1'b0, "level_w1c_after_drop");

        // FORCE, priority vector, unused bits, reserved addresses.
        wr(3'd1, 16'hFFFF);
        rd(3'd1, 16'h00FF, 1'b0, 1'b0, "enable_unused_bits");
        wr(3'd5, 16'h0088);
        rd(3'd0, 16'h0088, 1'b1, 1'b1, "force_pending");
        rd(3'd5, 16'h0000, 1'b0, 1'b0, "force_reads0");
        rd(3'd4, 16'h8003, 1'b0, 1'b0, "vector_bit3");
        wr(3'd0, 16'h0008);
        rd(3'd4, 16'h8007, 1'b1, 1'b1, "vector_bit7");
        wr(3'd6, 16'hFFFF);
        rd(3'd6, 16'h0000, 1'b0, 1'b0, "addr6_reads0");
        wr(3'd0, 16'h0080);
        rd(3'd4, 16'h0000, 1'b1, 1'b0, "vector_empty");

        // Edge on bit 1 reaches PENDING in the same cycle as a W1C of bit 1.
        wr(3'd1, 16'h0002);
        wr(3'd2, 16'h0002);
        irq_in[1] = 1'b1;
        tick(1);
        irq_in[1] = 1'b0;
        tick(1);
        wr(3'd0, 16'h0002);
        rd(3'd0, 16'h0002, 1'b1, 1'b1, "set_beats_clear");
        wr(3'd0, 16'h0002);
        rd(3'd0, 16'h0000, 1'b1, 1'b0, "set_beats_clear_cleanup");

        // Disabled source still latches; enabling it raises irq.
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0000);
        irq_in[0] = 1'b1;
        tick(1);
        irq_in[0] = 1'b0;
        tick(3);
        rd(3'd0, 16'h0001, 1'b1, 1'b0, "masked_pending");
        wr(3'd1, 16'h0001);
        rd(3'd3, 16'h0001, 1'b1, 1'b1, "unmask_irq");
        wr(3'd1, 16'h0000);
        rd(3'd3, 16'h0000, 1'b1, 1'b0, "mask_irq_falls");
        wr(3'd1, 16'h0001);
        rd(3'd0, 16'h0001, 1'b1, 1'b1, "remask_irq");
        tick(1);

        // Asynchronous reset mid-operation, checked between clock edges.
        reset_n = 1'b0;
        #2;
        check("async_rst_irq", {15'b0, irq}, 16'h0000);
        check("async_rst_readdata", readdata, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(3'd0, 16'h0000, 1'b1, 1'b0, "post_rst_pending");
        rd(3'd1, RST_EN, 1'b1, 1'b0, "post_rst_enable");
        rd(3'd2, 16'h0000, 1'b0, 1'b0, "post_rst_edge_mode");
        tick(2);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
